// File: rtl/bcd_display_scan.sv
// Four-digit BCD extender with sticky overflow and common-anode 7-segment scan.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  q_in,
    input  logic        z_in,
    output logic [15:0] count_bcd,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       z_d;
    logic       carry;

    logic [3:0] tens_nxt;
    logic [3:0] hundreds_nxt;
    logic [3:0] thousands_nxt;
    logic       ovf_nxt;

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [3:0]       sel_digit;
    logic             blank;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    // A held-high wrap flag must produce a single carry, so only its rising edge counts.
    assign carry = z_in & ~z_d;

    always_comb begin
        tens_nxt      = tens;
        hundreds_nxt  = hundreds;
        thousands_nxt = thousands;
        ovf_nxt       = ovf;
        if (carry) begin
            if (tens == 4'd9) begin
                tens_nxt = 4'd0;
                if (hundreds == 4'd9) begin
                    hundreds_nxt = 4'd0;
                    if (thousands == 4'd9) begin
                        thousands_nxt = 4'd0;
                        ovf_nxt       = 1'b1;
                    end else begin
                        thousands_nxt = thousands + 4'd1;
                    end
                end else begin
                    hundreds_nxt = hundreds + 4'd1;
                end
            end else begin
                tens_nxt = tens + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            units     <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            ovf       <= 1'b0;
            z_d       <= 1'b0;
        end else begin
            units     <= q_in;
            tens      <= tens_nxt;
            hundreds  <= hundreds_nxt;
            thousands <= thousands_nxt;
            ovf       <= ovf_nxt;
            z_d       <= z_in;
        end
    end

    assign count_bcd = {thousands, hundreds, tens, units};

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            idx <= 2'd0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        case (idx)
            2'd0:    sel_digit = units;
            2'd1:    sel_digit = tens;
            2'd2:    sel_digit = hundreds;
            default: sel_digit = thousands;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead3;
    logic lead2;
    logic lead1;
    assign lead3 = (thousands == 4'd0);
    assign lead2 = lead3 & (hundreds == 4'd0);
    assign lead1 = lead2 & (tens == 4'd0);

    always_comb begin
        case (idx)
            2'd1:    blank = lead1;
            2'd2:    blank = lead2;
            2'd3:    blank = lead3;
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_nxt = blank ? 7'b1111111 : seg_decode(sel_digit);
    assign an_nxt  = ~(4'b0001 << idx);

    // an and seg share one register stage so the anode never leads its segments.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan with a short scan divider.
module tb_bcd_display_scan;

    localparam int SD = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  q_in;
    logic        z_in;
    logic [15:0] count_bcd;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_chk;
    int n_pass;

    bcd_display_scan #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .z_in      (z_in),
        .count_bcd (count_bcd),
        .ovf       (ovf),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q_in  = 4'd0;
        z_in  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_carries(input int n);
        for (int i = 0; i < n; i++) begin
            z_in = 1'b1;
            tick();
            z_in = 1'b0;
            tick();
        end
    endtask

    // Stop on the first cycle in which the units anode is freshly lit.
    task automatic sync_units();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * SD + 4 && !found; i++) begin
            prev = an;
            tick();
            if (prev != 4'b1110 && an == 4'b1110) found = 1'b1;
        end
        check("scan_sync", {31'd0, found}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        for (int k = 0; k < 4 * SD; k++) begin
            check({tag, "_an"},  {28'd0, an},  {28'd0, exp_an[k / SD]});
            check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg[k / SD]});
            tick();
        end
    endtask

    logic [6:0] lead_seg;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        q_in   = 4'd0;
        z_in   = 1'b0;

        do_reset();
        check("rst_count", {16'd0, count_bcd}, 32'h0000);
        check("rst_ovf",   {31'd0, ovf},       32'd0);
        check("rst_an",    {28'd0, an},        32'hE);
        check("rst_seg",   {25'd0, seg},       32'h40);

        q_in = 4'd5;
        tick();
        check("units_copy", {16'd0, count_bcd}, 32'h0005);

        for (int i = 0; i < 10; i++) begin
            q_in = 4'(i);
            tick();
        end
        check("units_nine", {16'd0, count_bcd}, 32'h0009);
        q_in = 4'd0;
        z_in = 1'b1;
        tick();
        check("carry_edge", {16'd0, count_bcd}, 32'h0010);
        for (int i = 0; i < 20; i++) tick();
        check("carry_held", {16'd0, count_bcd}, 32'h0010);
        z_in = 1'b0;
        tick();
        check("carry_release", {16'd0, count_bcd}, 32'h0010);

        do_reset();
        do_carries(99);
        check("preload_0990", {16'd0, count_bcd}, 32'h0990);
        q_in = 4'd9;
        tick();
        check("preload_0999", {16'd0, count_bcd}, 32'h0999);
        q_in = 4'd0;
        z_in = 1'b1;
        tick();
        check("cascade_1000", {16'd0, count_bcd}, 32'h1000);
        z_in = 1'b0;
        tick();

        do_reset();
        do_carries(999);
        check("pre_ovf_count", {16'd0, count_bcd}, 32'h9990);
        check("pre_ovf_flag",  {31'd0, ovf},       32'd0);
        do_carries(1);
        check("ovf_count", {16'd0, count_bcd}, 32'h0000);
        check("ovf_flag",  {31'd0, ovf},       32'd1);
        do_carries(1);
        check("ovf_run_count", {16'd0, count_bcd}, 32'h0010);
        check("ovf_sticky",    {31'd0, ovf},       32'd1);
        do_reset();
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        q_in = 4'd4;
        do_carries(123);
        check("scan_count", {16'd0, count_bcd}, 32'h1234);
        sync_units();
        check_frame("scan", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        q_in = 4'hB;
        tick();
        check("dash_count", {16'd0, count_bcd}, 32'h123B);
        sync_units();
        check("dash_seg", {25'd0, seg}, 32'h3F);

        // A second carry arriving while the level is still high must be ignored.
        do_reset();
        z_in = 1'b1;
        tick();
        tick();
        check("reset_then_held", {16'd0, count_bcd}, 32'h0010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_discard", {16'd0, count_bcd}, 32'h0000);
        z_in = 1'b0;

        do_reset();
        q_in = 4'd7;
        tick();
        check("blank_count", {16'd0, count_bcd}, 32'h0007);
`ifdef LEADING_ZERO_BLANK_EN
        lead_seg = 7'b1111111;
`else
        lead_seg = 7'b1000000;
`endif
        sync_units();
        check_frame("blank", 7'b1111000, lead_seg, lead_seg, lead_seg);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
